// File: rtl/hamming_secded_decoder.sv
// Parametrised SECDED Hamming decoder: two-stage valid/ready pipeline with
// optional single-bit correction and saturating error counters.
module hamming_secded_decoder #(
    parameter int unsigned DW    = 8,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned P    = (DW <= 8) ? 4 : (DW <= 16) ? 5 : (DW <= 32) ? 6 : 7,
    localparam int unsigned CW   = DW + P + 1
) (
    input  logic             sys_clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    in_code,
    input  logic             correct_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [P-1:0]     out_syndrome,
    output logic             out_sec,
    output logic             out_ded,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam int unsigned NPOS = DW + P;

    logic          en;
    logic [P-1:0]  syn_c;
    logic          par_c;

    logic          s1_valid;
    logic [P-1:0]  s1_syn;
    logic          s1_par;
    logic [DW-1:0] s1_data;
    logic          s1_ce;

    logic          sec_c;
    logic          ded_c;
    logic [DW-1:0] data_c;

    // Both stages move together; a stalled result freezes the whole pipe.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Syndrome: check bits plus the position number of every set data bit.
    always_comb begin
        int unsigned k;
        syn_c = in_code[P-1:0];
        par_c = ^in_code;
        k     = 0;
        for (int unsigned pos = 3; pos <= NPOS; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (in_code[P + k]) syn_c = syn_c ^ P'(pos);
                k = k + 1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
            s1_data  <= '0;
            s1_ce    <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_syn   <= syn_c;
            s1_par   <= par_c;
            s1_data  <= in_code[P+DW-1:P];
            s1_ce    <= correct_en;
        end
    end

    // Classification; an odd-parity syndrome inside the codeword is a single error.
    always_comb begin
        int unsigned k;
        sec_c  = s1_par && (32'(s1_syn) <= NPOS);
        ded_c  = s1_par ? !sec_c : (s1_syn != '0);
        data_c = s1_data;
        k      = 0;
        for (int unsigned pos = 3; pos <= NPOS; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (sec_c && s1_ce && (32'(s1_syn) == pos)) data_c[k] = ~data_c[k];
                k = k + 1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_syndrome <= '0;
            out_sec      <= 1'b0;
            out_ded      <= 1'b0;
        end else if (en) begin
            out_valid    <= s1_valid;
            out_data     <= data_c;
            out_syndrome <= s1_syn;
            out_sec      <= s1_valid && sec_c;
            out_ded      <= s1_valid && ded_c;
        end
    end

    // Saturating counters; clear has priority over a coincident increment.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (out_sec && (corr_cnt != '1))   corr_cnt   <= corr_cnt + CNT_W'(1);
            if (out_ded && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Bench for hamming_secded_decoder: directed DW=8 checks (CNT_W=2) and a
// randomised DW=64 stream against a flip-count reference model.
module tb_hamming_secded_decoder;

    typedef struct packed {
        logic [63:0] data;
        logic [6:0]  syn;
        logic        sec;
        logic        ded;
    } res_t;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // DW=8, CNT_W=2 instance
    logic        rstn8 = 1'b0, in_valid8 = 1'b0, ce8 = 1'b0, out_ready8 = 1'b1, cnt_clr8 = 1'b0;
    logic [12:0] in_code8 = '0;
    logic        in_ready8, out_valid8, out_sec8, out_ded8;
    logic [7:0]  out_data8;
    logic [3:0]  out_syn8;
    logic [1:0]  corr8, uncorr8;

    // DW=64, CNT_W=16 instance
    logic        rstn64 = 1'b0, in_valid64 = 1'b0, ce64 = 1'b0, out_ready64 = 1'b1, cnt_clr64 = 1'b0;
    logic [71:0] in_code64 = '0;
    logic        in_ready64, out_valid64, out_sec64, out_ded64;
    logic [63:0] out_data64;
    logic [6:0]  out_syn64;
    logic [15:0] corr64, uncorr64;

    hamming_secded_decoder #(.DW(8), .CNT_W(2)) u8 (
        .sys_clk(sys_clk), .rstn(rstn8), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_code(in_code8), .correct_en(ce8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_data(out_data8), .out_syndrome(out_syn8), .out_sec(out_sec8), .out_ded(out_ded8),
        .cnt_clr(cnt_clr8), .corr_cnt(corr8), .uncorr_cnt(uncorr8)
    );

    hamming_secded_decoder #(.DW(64), .CNT_W(16)) u64 (
        .sys_clk(sys_clk), .rstn(rstn64), .in_valid(in_valid64), .in_ready(in_ready64),
        .in_code(in_code64), .correct_en(ce64), .out_valid(out_valid64), .out_ready(out_ready64),
        .out_data(out_data64), .out_syndrome(out_syn64), .out_sec(out_sec64), .out_ded(out_ded64),
        .cnt_clr(cnt_clr64), .corr_cnt(corr64), .uncorr_cnt(uncorr64)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   dpos[64];
    res_t got8[$];
    res_t q64[$];
    res_t cur_exp64 = '0;
    int   mcorr = 0;
    int   mded  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_res(input string name, input res_t g, input res_t e);
        check({name, ".data"}, g.data, e.data);
        check({name, ".syn"}, 64'(g.syn), 64'(e.syn));
        check({name, ".sec"}, 64'(g.sec), 64'(e.sec));
        check({name, ".ded"}, 64'(g.ded), 64'(e.ded));
    endtask

    // Reference encoder: check bit i is the parity of data bits whose position has bit i set.
    function automatic logic [71:0] encode(input logic [63:0] d, input int dw);
        logic [71:0] c;
        int p;
        c = '0;
        p = (dw == 8) ? 4 : (dw == 16) ? 5 : (dw == 32) ? 6 : 7;
        for (int k = 0; k < dw; k++) c[p + k] = d[k];
        for (int i = 0; i < p; i++)
            for (int k = 0; k < dw; k++)
                if (((dpos[k] >> i) & 1) != 0) c[i] = c[i] ^ d[k];
        c[dw + p] = ^c;
        return c;
    endfunction

    function automatic int pos_of64(input int idx);
        if (idx < 7) return 1 << idx;
        if (idx < 71) return dpos[idx - 7];
        return 0;
    endfunction

    function automatic res_t mk(input logic [63:0] d, input int syn, input logic sec, input logic ded);
        res_t r;
        r.data = d;
        r.syn  = 7'(syn);
        r.sec  = sec;
        r.ded  = ded;
        return r;
    endfunction

    // DW=8 result collector
    always @(negedge sys_clk) begin
        if (rstn8 && out_valid8 && out_ready8)
            got8.push_back(mk(64'(out_data8), int'(out_syn8), out_sec8, out_ded8));
    end

    // DW=64 scoreboard: every cycle, counters and transfers against the model
    always @(negedge sys_clk) begin
        res_t g, e;
        if (!rstn64) begin
            q64.delete();
            mcorr = 0;
            mded  = 0;
            check("rst64.out_valid", 64'(out_valid64), 64'(0));
            check("rst64.out_data", out_data64, 64'(0));
            check("rst64.syn", 64'(out_syn64), 64'(0));
            check("rst64.secded", 64'({out_sec64, out_ded64}), 64'(0));
            check("rst64.cnts", 64'({corr64, uncorr64}), 64'(0));
        end else begin
            check("u64.corr_cnt", 64'(corr64), 64'(mcorr));
            check("u64.uncorr_cnt", 64'(uncorr64), 64'(mded));
            if (out_valid64) check("u64.sec_ded_excl", 64'(out_sec64 & out_ded64), 64'(0));
            if (out_valid64 && out_ready64) begin
                g = mk(out_data64, int'(out_syn64), out_sec64, out_ded64);
                if (q64.size() == 0) begin
                    check("u64.unexpected_result", 64'(1), 64'(0));
                end else begin
                    e = q64.pop_front();
                    cmp_res("u64", g, e);
                    mcorr += int'(e.sec);
                    mded  += int'(e.ded);
                end
            end
            if (in_valid64 && in_ready64) q64.push_back(cur_exp64);
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send8(input logic [12:0] code, input logic ce);
        logic acc;
        int n;
        in_code8  = code;
        ce8       = ce;
        in_valid8 = 1'b1;
        n = 0;
        do begin
            @(negedge sys_clk);
            acc = in_ready8;
            tick();
            n++;
        end while (!acc && n < 20);
        check("send8.accept", 64'(acc), 64'(1));
        in_valid8 = 1'b0;
    endtask

    task automatic result8(input string name, input res_t e);
        int n;
        n = 0;
        while (got8.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        check({name, ".present"}, 64'(got8.size() != 0), 64'(1));
        if (got8.size() != 0) cmp_res(name, got8.pop_front(), e);
    endtask

    task automatic run_random64(input int n_items);
        res_t e;
        logic [63:0] d;
        logic [71:0] code;
        logic acc;
        int nf, b1, b2, n;
        for (int i = 0; i < n_items; i++) begin
            if (i == n_items / 2) begin
                // Asynchronous reset with results in flight
                in_valid64 = 1'b0;
                rstn64 = 1'b0;
                #1;
                check("rst64.async_valid", 64'(out_valid64), 64'(0));
                check("rst64.async_data", out_data64, 64'(0));
                check("rst64.async_cnt", 64'(corr64), 64'(0));
                tick();
                tick();
                rstn64 = 1'b1;
                #1;
                check("rst64.in_ready", 64'(in_ready64), 64'(1));
            end
            if ($urandom_range(4, 0) == 0) begin
                in_valid64  = 1'b0;
                out_ready64 = $urandom_range(3, 0) != 0;
                tick();
            end
            d    = {$urandom, $urandom};
            code = encode(d, 64);
            nf   = $urandom_range(2, 0);
            b1   = $urandom_range(71, 0);
            do b2 = $urandom_range(71, 0); while (b2 == b1);
            ce64 = $urandom_range(1, 0) != 0;
            e = mk(d, 0, 1'b0, 1'b0);
            if (nf >= 1) code[b1] = ~code[b1];
            if (nf == 2) code[b2] = ~code[b2];
            if (nf == 1) begin
                e.sec = 1'b1;
                e.syn = 7'(pos_of64(b1));
                if (b1 >= 7 && b1 < 71 && !ce64) e.data[b1 - 7] = ~e.data[b1 - 7];
            end else if (nf == 2) begin
                e.ded = 1'b1;
                e.syn = 7'(pos_of64(b1) ^ pos_of64(b2));
                if (b1 >= 7 && b1 < 71) e.data[b1 - 7] = ~e.data[b1 - 7];
                if (b2 >= 7 && b2 < 71) e.data[b2 - 7] = ~e.data[b2 - 7];
            end
            cur_exp64  = e;
            in_code64  = code;
            in_valid64 = 1'b1;
            n = 0;
            do begin
                out_ready64 = $urandom_range(3, 0) != 0;
                @(negedge sys_clk);
                acc = in_ready64;
                tick();
                n++;
            end while (!acc && n < 50);
            check("send64.accept", 64'(acc), 64'(1));
        end
        in_valid64  = 1'b0;
        out_ready64 = 1'b1;
        n = 0;
        while (q64.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("u64.drained", 64'(q64.size()), 64'(0));
    endtask

    initial begin
        int n;
        logic acc;
        n = 0;
        for (int p = 1; n < 64; p++) begin
            if ((p & (p - 1)) != 0) begin
                dpos[n] = p;
                n++;
            end
        end

        // Hand-computed pins on the reference model
        check("model.dpos0", 64'(dpos[0]), 64'(3));
        check("model.dpos4", 64'(dpos[4]), 64'(9));
        check("model.enc_ff", encode(64'hFF, 8), 72'h0FF3);
        check("model.enc_01", encode(64'h01, 8), 72'h1013);
        check("model.pos71", 64'(pos_of64(71)), 64'(0));

        @(negedge sys_clk);
        check("rst8.out_valid", 64'(out_valid8), 64'(0));
        check("rst8.out_data", 64'(out_data8), 64'(0));
        check("rst8.cnts", 64'({corr8, uncorr8}), 64'(0));
        tick();
        rstn8  = 1'b1;
        rstn64 = 1'b1;
        #1;
        check("rst8.in_ready", 64'(in_ready8), 64'(1));

        // Clean stream: output appears in the second cycle after the first accept
        in_code8  = 13'h0000;
        in_valid8 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge sys_clk);
            check("clean.out_valid", 64'(out_valid8), 64'(k >= 2));
            if (k >= 2) cmp_res("clean", mk(64'(out_data8), int'(out_syn8), out_sec8, out_ded8), mk(64'h0, 0, 1'b0, 1'b0));
            tick();
        end
        in_valid8 = 1'b0;
        tick();
        tick();
        tick();
        check("clean.cnts", 64'({corr8, uncorr8}), 64'(0));
        got8.delete();

        send8(13'h0010, 1'b1);
        result8("d0_corr", mk(64'h00, 3, 1'b1, 1'b0));
        check("d0_corr.corr_cnt", 64'(corr8), 64'(1));
        send8(13'h0010, 1'b0);
        result8("d0_detect", mk(64'h01, 3, 1'b1, 1'b0));
        send8(13'h0030, 1'b1);
        result8("d01_ded", mk(64'h03, 6, 1'b0, 1'b1));
        check("d01_ded.uncorr_cnt", 64'(uncorr8), 64'(1));
        send8(13'h1000, 1'b1);
        result8("gpar", mk(64'h00, 0, 1'b1, 1'b0));
        send8(13'h0002, 1'b1);
        result8("chk1", mk(64'h00, 2, 1'b1, 1'b0));

        // Backpressure: 4 codewords, consumer stalls 3 cycles after the first result
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    in_code8  = encode(64'(i + 1), 8)[12:0];
                    ce8       = 1'b1;
                    in_valid8 = 1'b1;
                    n = 0;
                    do begin
                        @(negedge sys_clk);
                        acc = in_ready8;
                        tick();
                        n++;
                    end while (!acc && n < 20);
                    check("bp.accept", 64'(acc), 64'(1));
                end
                in_valid8 = 1'b0;
            end
            begin
                n = 0;
                do begin
                    @(negedge sys_clk);
                    n++;
                end while (!out_valid8 && n < 20);
                check("bp.first_valid", 64'(out_valid8), 64'(1));
                tick();
                out_ready8 = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge sys_clk);
                    check("bp.stall_in_ready", 64'(in_ready8), 64'(0));
                    check("bp.stall_valid", 64'(out_valid8), 64'(1));
                    check("bp.stall_data", 64'(out_data8), 64'(2));
                    tick();
                end
                out_ready8 = 1'b1;
            end
        join
        for (int i = 0; i < 4; i++) result8("bp.order", mk(64'(i + 1), 0, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) tick();
        check("bp.no_dup", 64'(got8.size()), 64'(0));

        // Saturation with CNT_W=2, then clear coinciding with a sec transfer
        cnt_clr8 = 1'b1;
        tick();
        cnt_clr8 = 1'b0;
        check("cnt.clr", 64'({corr8, uncorr8}), 64'(0));
        for (int i = 0; i < 5; i++) begin
            send8(13'h0010, 1'b1);
            result8("cnt.sec", mk(64'h00, 3, 1'b1, 1'b0));
        end
        check("cnt.saturate", 64'(corr8), 64'(3));
        send8(13'h0010, 1'b1);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!out_valid8 && n < 20);
        check("cnt.clr_valid", 64'(out_valid8), 64'(1));
        cnt_clr8 = 1'b1;
        tick();
        cnt_clr8 = 1'b0;
        check("cnt.clr_wins", 64'(corr8), 64'(0));
        got8.delete();

        run_random64(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_secded_decoder.md
Name: hamming_secded_decoder

Overview:
- Parametrised successor to the 12,8 Hamming decoder. Single-error-correct, double-error-detect (SECDED) for a configurable data width.
- Two-stage registered pipeline with a valid/ready handshake, a correction-enable mode, and saturating error counters.
- Sits between the memory/link read path and the consumer. Pairs with a matching SECDED encoder that uses the same codeword layout.

Parameters:
- DW, 8, data width; legal values 8, 16, 32, 64.
- P, derived (4/5/6/7 for DW 8/16/32/64), number of Hamming check bits. Localparam, not overridable.
- CW, derived DW+P+1, codeword width.
- CNT_W, 16, width of each error counter.

Ports:
- sys_clk  in  1  clock, all flops on rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  codeword present
- in_ready  out  1  decoder accepts codeword this cycle
- in_code  in  CW  codeword: [P-1:0] check bits, [P+DW-1:P] data, [CW-1] overall parity
- correct_en  in  1  1 = correct single errors, 0 = detect only; sampled with the codeword
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  DW  decoded (possibly corrected) data
- out_syndrome  out  P  Hamming syndrome of the result
- out_sec  out  1  single error seen (corrected when correct_en=1)
- out_ded  out  1  uncorrectable error
- cnt_clr  in  1  synchronous clear of both counters
- corr_cnt  out  CNT_W  count of accepted results with out_sec=1
- uncorr_cnt  out  CNT_W  count of accepted results with out_ded=1

Behaviour:
- Position mapping: Hamming positions start at 1. Check bit i is at position 2^i. Data bit k is at the k-th non-power-of-two position, ascending (bit0=3, bit1=5, bit2=6, bit3=7, bit4=9, ...). Check bit i covers every position with bit i set.
- Syndrome: S[i] = check bit i XOR covered data bits. G = XOR of all CW bits (even overall parity).
- Classification:
  - S=0, G=0: clean.
  - G=1, S=0: overall-parity bit in error. Data unchanged, sec=1.
  - G=1, S a power of two: check bit in error. Data unchanged, sec=1.
  - G=1, S a data position: flip that data bit if correct_en=1, else pass raw. sec=1.
  - G=1, S beyond DW+P: ded=1, data raw.
  - S!=0, G=0: ded=1, data raw.
  - sec and ded are never both 1.
- Pipeline:
  - Stage 1 registers S, G, raw data, correct_en and a valid bit.
  - Stage 2 registers out_data, out_syndrome, out_sec, out_ded and out_valid.
  - en = !out_valid | out_ready. in_ready = en. Both stages advance only when en=1.
  - Latency 2 cycles from accepted input to out_valid with no stall. Full throughput is 1 codeword per cycle.
- Stall behaviour: while out_valid=1 and out_ready=0, all out_* outputs and stage 1 hold stable and in_ready=0. No data is lost or duplicated.
- Counters: increment on each out_valid & out_ready transfer whose out_sec (or out_ded) is 1. They saturate at all-ones. When cnt_clr coincides with an increment, the clear wins (result 0).
- Reset: asynchronous, and also applies mid-operation. All flops go to 0; in-flight codewords are discarded. out_valid=0, out_data=0, out_syndrome=0, out_sec=0, out_ded=0, both counters=0. in_ready=1 immediately after reset release.

Test Plan:
- DW=8. Stream clean all-zero codeword 13'h0000 every cycle, out_ready=1. Expect: out_valid 2 cycles after the first accept, out_data=0x00, syndrome 0, sec=0, ded=0, counters remain 0.
- DW=8, in_code=13'h0010 (data bit0 flipped), correct_en=1. Expect: out_data=0x00, out_syndrome=3, sec=1, corr_cnt=1. Same input with correct_en=0. Expect: out_data=0x01, sec=1.
- DW=8, in_code=13'h0030 (data bits 0 and 1 flipped). Expect: out_syndrome=6, ded=1, out_data=0x03 (raw), uncorr_cnt=1. Also 13'h1000 (overall parity bit only). Expect: syndrome 0, sec=1, data 0x00.
- Backpressure: 4 back-to-back codewords, out_ready low for 3 cycles after the first result. Expect: in_ready=0 during the stall, outputs held, all 4 delivered in order exactly once.
- Counters, CNT_W=2: 5 single-error transfers. Expect: corr_cnt saturates at 3. Then cnt_clr on the same cycle as a sec transfer. Expect: corr_cnt=0.
- DW=64 randomised: encoder model plus 0, 1 or 2 random bit flips, with rstn pulsed low mid-stream. Expect: every non-reset result matches the model. Outputs go to 0 asynchronously during reset, and no pre-reset result appears afterwards.
